// File: rtl/road_sensor_conditioner.sv
// ---------------------------------------------------------------------------------------------
// road_sensor_conditioner
//
// Upstream stage of the four-way signal controller. Each road's raw detector bits are
// synchronised, debounced bit by bit, clamped to a legal congestion code and then passed
// through a rise-fast / fall-slow hysteresis filter before driving the controller's S inputs.
//
// Ports:
//   clock      system clock, all state changes on its rising edge
//   clear      asynchronous active-high reset
//   raw1..4    road detectors (bit0 near, bit1 mid, bit2 far), asynchronous to clock
//   S1..S4     congestion codes: EMPTY=000, LESS=001, MORE=011, FULL=111
//   chg        chg[i-1] pulses for one cycle after the edge at which Si changed
//
// Parameters:
//   DEBOUNCE   consecutive mismatching samples needed to accept a raw bit change (1..15)
//   HOLD       consecutive cycles a lower level must persist before S drops (1..255)
// ---------------------------------------------------------------------------------------------
module road_sensor_conditioner #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned HOLD     = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [2:0] raw1,
    input  logic [2:0] raw2,
    input  logic [2:0] raw3,
    input  logic [2:0] raw4,
    output logic [2:0] S1,
    output logic [2:0] S2,
    output logic [2:0] S3,
    output logic [2:0] S4,
    output logic [3:0] chg
);

    localparam logic [2:0] Empty = 3'b000;
    localparam logic [2:0] Less  = 3'b001;
    localparam logic [2:0] More  = 3'b011;
    localparam logic [2:0] Full  = 3'b111;

    // Terminal counts; counters are only ever compared for equality and cleared.
    localparam logic [3:0] DbLast   = 4'(DEBOUNCE - 1);
    localparam logic [7:0] HoldLast = 8'(HOLD - 1);

    // Out-of-range sizing is reported during elaboration only.
    if (DEBOUNCE == 0 || DEBOUNCE > 15) begin : g_bad_debounce
        $error("road_sensor_conditioner: DEBOUNCE=%0d outside 1..15", DEBOUNCE);
    end
    if (HOLD == 0 || HOLD > 255) begin : g_bad_hold
        $error("road_sensor_conditioner: HOLD=%0d outside 1..255", HOLD);
    end

    logic [3:0][2:0] raw_all;
    logic [3:0][2:0] s_all;

    assign raw_all = {raw4, raw3, raw2, raw1};

    assign S1 = s_all[0];
    assign S2 = s_all[1];
    assign S3 = s_all[2];
    assign S4 = s_all[3];

    for (genvar r = 0; r < 4; r++) begin : g_road
        logic [2:0]      sync1_q;
        logic [2:0]      sync2_q;
        logic [2:0]      db_q;
        logic [2:0]      db_d;
        logic [2:0][3:0] dcnt_q;
        logic [2:0][3:0] dcnt_d;
        logic [2:0]      level;
        logic [2:0]      s_q;
        logic [2:0]      s_d;
        logic [7:0]      hcnt_q;
        logic [7:0]      hcnt_d;
        logic            chg_q;

        // Two-flop synchroniser; only sync2_q is used downstream.
        always_ff @(posedge clock or posedge clear) begin
            if (clear) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= raw_all[r];
                sync2_q <= sync1_q;
            end
        end

        // Per-bit debounce: any sample equal to the accepted bit restarts the count.
        always_comb begin
            db_d   = db_q;
            dcnt_d = dcnt_q;
            for (int b = 0; b < 3; b++) begin
                if (sync2_q[b] == db_q[b]) begin
                    dcnt_d[b] = '0;
                end else if (dcnt_q[b] == DbLast) begin
                    db_d[b]   = sync2_q[b];
                    dcnt_d[b] = '0;
                end else begin
                    dcnt_d[b] = dcnt_q[b] + 4'd1;
                end
            end
        end

        // Clamp to the longest run of ones starting at the near detector.
        assign level = db_q[0] ? (db_q[1] ? (db_q[2] ? Full : More) : Less) : Empty;

        // Hysteresis: rise immediately, fall only after HOLD cycles below S. The hold count
        // keeps running while level stays below S even if level itself steps.
        always_comb begin
            s_d    = s_q;
            hcnt_d = hcnt_q;
            if (level > s_q) begin
                s_d    = level;
                hcnt_d = '0;
            end else if (level == s_q) begin
                hcnt_d = '0;
            end else if (hcnt_q == HoldLast) begin
                s_d    = level;
                hcnt_d = '0;
            end else begin
                hcnt_d = hcnt_q + 8'd1;
            end
        end

        always_ff @(posedge clock or posedge clear) begin
            if (clear) begin
                db_q   <= '0;
                dcnt_q <= '0;
                s_q    <= Empty;
                hcnt_q <= '0;
                chg_q  <= 1'b0;
            end else begin
                db_q   <= db_d;
                dcnt_q <= dcnt_d;
                s_q    <= s_d;
                hcnt_q <= hcnt_d;
                chg_q  <= (s_d != s_q);
            end
        end

        assign s_all[r] = s_q;
        assign chg[r]   = chg_q;
    end

endmodule
